// File: rtl/inst_encoder_if.sv
`default_nettype none
// =============================================================================
// inst_encoder_if : byte stream in, instruction-FIFO write port out
// Revision: 1.0
// =============================================================================
interface inst_encoder_if #(
    parameter int DATA_W = 82
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              sof;
    logic              byte_ready;
    logic              fifo_full;
    logic              fifo_wenable;
    logic [DATA_W-1:0] fifo_wdata;
    logic              frame_err;
    logic [7:0]        inst_count;

    modport master (
        output byte_in, byte_valid, sof, fifo_full,
        input  byte_ready, fifo_wenable, fifo_wdata, frame_err, inst_count
    );

    modport slave (
        input  byte_in, byte_valid, sof, fifo_full,
        output byte_ready, fifo_wenable, fifo_wdata, frame_err, inst_count
    );
endinterface
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// =============================================================================
// inst_encoder : packs an 11-byte frame into a sanitized 82-bit FIFO word
// Revision: 1.0
// =============================================================================
module inst_encoder #(
    parameter int DATA_W    = 82,
    parameter int NUM_BYTES = 11
) (
    input  wire             clk,
    input  wire             n_rst,
    inst_encoder_if.slave   bus
);
    localparam int c_FRAME_W = NUM_BYTES * 8;
    localparam int c_HOLD_W  = (NUM_BYTES - 1) * 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUSH    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [3:0]            w_idx;
    logic [c_HOLD_W-1:0]   r_shift;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_frame_err;
    logic [7:0]            r_count;
    logic                  w_accept;
    logic                  w_store;
    logic                  w_load;
    logic                  w_err;
    logic                  w_wen;
    logic [c_FRAME_W-1:0]  w_frame;

    function automatic logic [DATA_W-1:0] sanitize(input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] w;
        w = raw;
        if (raw[0]) begin
            w = {77'b0, raw[4:1], 1'b1};
        end else begin
            if (!raw[1])  w[49:34] = '0;
            if (!raw[51]) w[77:76] = '0;
            else          w[75:52] = '0;
        end
        return w;
    endfunction

    // The final byte is taken straight from the bus so the word can be judged
    // and registered in the same cycle it is accepted.
    assign w_frame  = {bus.byte_in, r_shift};
    assign w_accept = bus.byte_valid && (r_state != PUSH);
    assign w_wen    = (r_state == PUSH) && !bus.fifo_full;

    assign bus.byte_ready   = (r_state != PUSH);
    assign bus.fifo_wenable = w_wen;
    assign bus.fifo_wdata   = r_wdata;
    assign bus.frame_err    = r_frame_err;
    assign bus.inst_count   = r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx        = r_cnt;
        w_store      = 1'b0;
        w_load       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.sof) begin
                        w_store      = 1'b1;
                        w_idx        = 4'd0;
                        w_cnt_next   = 4'd1;
                        w_state_next = COLLECT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    if (bus.sof) begin
                        w_err      = 1'b1;
                        w_store    = 1'b1;
                        w_idx      = 4'd0;
                        w_cnt_next = 4'd1;
                    end else if (r_cnt == 4'(NUM_BYTES - 1)) begin
                        w_cnt_next = 4'd0;
                        if (w_frame[c_FRAME_W-1:DATA_W] != '0) begin
                            w_err        = 1'b1;
                            w_state_next = IDLE;
                        end else begin
                            w_load       = 1'b1;
                            w_state_next = PUSH;
                        end
                    end else begin
                        w_store    = 1'b1;
                        w_cnt_next = r_cnt + 4'd1;
                    end
                end
            end
            PUSH: begin
                if (w_wen) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt       <= 4'd0;
            r_shift     <= '0;
            r_wdata     <= '0;
            r_frame_err <= 1'b0;
            r_count     <= 8'd0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_frame_err <= w_err;
            if (w_store) r_shift[{w_idx, 3'b000} +: 8] <= bus.byte_in;
            if (w_load)  r_wdata <= sanitize(w_frame[DATA_W-1:0]);
            if (w_wen)   r_count <= r_count + 8'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// =============================================================================
// tb_inst_encoder : directed table-driven bench for inst_encoder
// Revision: 1.0
// =============================================================================
module tb_inst_encoder;
    logic clk;
    logic n_rst;
    int   n_checks;
    int   n_pass;
    int   wr_cnt;
    int   err_cnt;
    logic [81:0] last_wdata;

    inst_encoder_if #(.DATA_W(82)) bus ();

    inst_encoder #(.DATA_W(82), .NUM_BYTES(11)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [87:0] frame;
        logic        err;
        logic [81:0] data;
    } vec_t;

    vec_t vecs[7];

    always @(posedge clk) begin
        if (bus.fifo_wenable) begin
            wr_cnt     = wr_cnt + 1;
            last_wdata = bus.fifo_wdata;
            if (bus.fifo_full) begin
                n_checks = n_checks + 1;
                $display("FAIL wen_while_full: fifo_wenable=1 required 0");
            end
        end
        if (bus.frame_err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [87:0] mk(input logic t, input logic v, input logic [15:0] a,
                                       input logic [15:0] b, input logic [15:0] c,
                                       input logic layer, input logic fill,
                                       input logic [23:0] color, input logic [1:0] tex,
                                       input logic [3:0] alpha);
        return {6'b0, alpha, tex, color, fill, layer, c, b, a, v, t};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic s);
        @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        bus.sof        = s;
    endtask

    // Ends on the negedge after the last byte's accepting edge (the PUSH cycle).
    task automatic send_frame(input logic [87:0] f);
        for (int i = 0; i < 11; i++) send_byte(f[i*8 +: 8], i == 0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.sof        = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, 128'(bus.byte_ready),   128'd1);
        check({tag, "_wenable"},    128'(bus.fifo_wenable), 128'd0);
        check({tag, "_wdata"},      128'(bus.fifo_wdata),   128'd0);
        check({tag, "_frame_err"},  128'(bus.frame_err),    128'd0);
        check({tag, "_inst_count"}, 128'(bus.inst_count),   128'd0);
    endtask

    initial begin
        logic [87:0] tmp;
        logic [87:0] fx;
        logic [87:0] fy;
        logic [81:0] ey;
        int w0, e0;
        int exp_count;

        n_checks = 0; n_pass = 0; wr_cnt = 0; err_cnt = 0; last_wdata = '0;
        bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.sof = 1'b0; bus.fifo_full = 1'b0;
        n_rst = 1'b0;

        vecs[0].frame = mk(1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b0, 24'hABCDEF, 2'b11, 4'h5);
        vecs[0].err   = 1'b0;
        tmp           = mk(1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b0, 24'hABCDEF, 2'b00, 4'h5);
        vecs[0].data  = tmp[81:0];
        vecs[1].frame = {8'h03, {10{8'hFF}}};
        vecs[1].err   = 1'b0;
        vecs[1].data  = 82'h1F;
        vecs[2].frame = mk(1'b0, 1'b0, 16'hA1A1, 16'hB2B2, 16'hC3C3, 1'b0, 1'b1, 24'h123456, 2'b10, 4'h9);
        vecs[2].err   = 1'b0;
        tmp           = mk(1'b0, 1'b0, 16'hA1A1, 16'hB2B2, 16'h0000, 1'b0, 1'b1, 24'h000000, 2'b10, 4'h9);
        vecs[2].data  = tmp[81:0];
        vecs[3].frame = mk(1'b0, 1'b1, 16'h0001, 16'h0002, 16'h0003, 1'b1, 1'b1, 24'hFFFFFF, 2'b01, 4'hF);
        vecs[3].err   = 1'b0;
        tmp           = mk(1'b0, 1'b1, 16'h0001, 16'h0002, 16'h0003, 1'b1, 1'b1, 24'h000000, 2'b01, 4'hF);
        vecs[3].data  = tmp[81:0];
        vecs[4].frame = {8'h01, {9{8'h5A}}, 8'hB5};
        vecs[4].err   = 1'b0;
        vecs[4].data  = 82'h15;
        tmp           = mk(1'b0, 1'b1, 16'h1234, 16'h5678, 16'h9ABC, 1'b0, 1'b0, 24'h0F0F0F, 2'b00, 4'h1);
        vecs[5].frame = {8'h40, tmp[79:0]};
        vecs[5].err   = 1'b1;
        vecs[5].data  = '0;
        vecs[6].frame = mk(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 24'h00FF00, 2'b11, 4'h0);
        vecs[6].err   = 1'b0;
        tmp           = mk(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 24'h00FF00, 2'b00, 4'h0);
        vecs[6].data  = tmp[81:0];

        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        exp_count = 0;

        foreach (vecs[k]) begin
            w0 = wr_cnt; e0 = err_cnt;
            send_frame(vecs[k].frame);
            if (!vecs[k].err) begin
                check($sformatf("v%0d_wen_latency", k), 128'(bus.fifo_wenable), 128'd1);
                check($sformatf("v%0d_wdata", k), 128'(bus.fifo_wdata), 128'(vecs[k].data));
                exp_count++;
            end
            @(negedge clk);
            check($sformatf("v%0d_writes", k), 128'(wr_cnt - w0), 128'(vecs[k].err ? 0 : 1));
            check($sformatf("v%0d_errs", k), 128'(err_cnt - e0), 128'(vecs[k].err ? 1 : 0));
            check($sformatf("v%0d_inst_count", k), 128'(bus.inst_count), 128'(exp_count[7:0]));
        end

        // Backpressure: FIFO full for 5 cycles in PUSH.
        w0 = wr_cnt;
        bus.fifo_full = 1'b1;
        send_frame(vecs[0].frame);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("full_wen_c%0d", i), 128'(bus.fifo_wenable), 128'd0);
            check($sformatf("full_ready_c%0d", i), 128'(bus.byte_ready), 128'd0);
            check($sformatf("full_wdata_c%0d", i), 128'(bus.fifo_wdata), 128'(vecs[0].data));
            @(negedge clk);
        end
        bus.fifo_full = 1'b0;
        #1;
        check("full_release_wen", 128'(bus.fifo_wenable), 128'd1);
        @(negedge clk);
        exp_count++;
        check("full_one_write", 128'(wr_cnt - w0), 128'd1);
        check("full_wdata_written", 128'(last_wdata), 128'(vecs[0].data));
        check("full_wen_after", 128'(bus.fifo_wenable), 128'd0);

        // Restart on sof at byte 6: only the new frame is written.
        fx = vecs[2].frame;
        fy = vecs[3].frame;
        ey = vecs[3].data;
        w0 = wr_cnt; e0 = err_cnt;
        for (int i = 0; i < 6; i++) send_byte(fx[i*8 +: 8], i == 0);
        send_frame(fy);
        check("restart_wdata", 128'(bus.fifo_wdata), 128'(ey));
        @(negedge clk);
        exp_count++;
        check("restart_writes", 128'(wr_cnt - w0), 128'd1);
        check("restart_errs", 128'(err_cnt - e0), 128'd1);

        // Stray byte in IDLE.
        w0 = wr_cnt; e0 = err_cnt;
        send_byte(8'h12, 1'b0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        check("stray_err_pulse", 128'(bus.frame_err), 128'd1);
        @(negedge clk);
        check("stray_err_single", 128'(bus.frame_err), 128'd0);
        check("stray_errs", 128'(err_cnt - e0), 128'd1);
        check("stray_writes", 128'(wr_cnt - w0), 128'd0);
        check("stray_inst_count", 128'(bus.inst_count), 128'(exp_count[7:0]));

        // 256 back-to-back frames wrap the counter to its starting value.
        w0 = wr_cnt;
        for (int n = 0; n < 255; n++) send_frame(vecs[n % 2].frame);
        @(negedge clk);
        check("wrap_count_255", 128'(bus.inst_count), 128'((exp_count + 255) % 256));
        send_frame(vecs[6].frame);
        @(negedge clk);
        check("wrap_writes", 128'(wr_cnt - w0), 128'd256);
        check("wrap_count_256", 128'(bus.inst_count), 128'(exp_count[7:0]));

        // Async reset mid-frame.
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) send_byte(fx[i*8 +: 8], i == 0);
        @(negedge clk);
        bus.byte_in = fx[47:40];
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        bus.byte_valid = 1'b0;
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_writes", 128'(wr_cnt - w0), 128'd0);
        check_reset_outputs("postreset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
